// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-master OBI core arbiter.
package obi_arb_pkg;

   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   localparam int          MAX_OUTSTANDING_DEFAULT = 2;
   localparam logic [3:0]  BE_FULL                 = 4'hF;
   localparam logic [31:0] WDATA_NONE              = 32'h0;

endpackage

// File: rtl/obi_core_arbiter_if.sv
// Bundle of the instruction, data and memory-side OBI signals around the arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface obi_core_arbiter_if;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;

   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );
endinterface

// File: rtl/obi_owner_fifo.sv
// In-order FIFO of response owners; one entry per granted, not yet answered transaction.
module obi_owner_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 1,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/obi_core_arbiter.sv
// Round-robin arbiter merging the core instruction and data OBI ports onto one memory port,
// with request lock until grant and zero-latency in-order response routing.
module obi_core_arbiter
   import obi_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
   input logic               clk,
   input logic               rst_n,
   obi_core_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   owner_e        rr_last;
   owner_e        lock_owner;
   owner_e        sel;
   owner_e        head_owner;
   logic          lock;
   logic          sel_req;
   logic          mem_req;
   logic          grant;
   logic          resp;
   logic          fifo_full;
   logic          fifo_empty;
   logic [0:0]    head_bit;
   logic [CW-1:0] count;

   always_comb begin
      sel = OWNER_INSTR;
      if (lock)
         sel = lock_owner;
      else if (bus.instr_req_i && bus.data_req_i)
         sel = (rr_last == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
      else if (bus.data_req_i)
         sel = OWNER_DATA;
   end

   assign sel_req = (sel == OWNER_DATA) ? bus.data_req_i : bus.instr_req_i;
   // rst_n gates the request so nothing leaks onto the bus while held in reset.
   assign mem_req = rst_n && sel_req && (count < CW'(MAX_OUTSTANDING));
   assign grant   = mem_req && bus.mem_gnt_i;

   assign bus.mem_req_o   = mem_req;
   assign bus.mem_we_o    = (sel == OWNER_DATA) ? bus.data_we_i    : 1'b0;
   assign bus.mem_be_o    = (sel == OWNER_DATA) ? bus.data_be_i    : BE_FULL;
   assign bus.mem_addr_o  = (sel == OWNER_DATA) ? bus.data_addr_i  : bus.instr_addr_i;
   assign bus.mem_wdata_o = (sel == OWNER_DATA) ? bus.data_wdata_i : WDATA_NONE;
   assign bus.instr_gnt_o = grant && (sel == OWNER_INSTR);
   assign bus.data_gnt_o  = grant && (sel == OWNER_DATA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last    <= OWNER_DATA;
         lock       <= 1'b0;
         lock_owner <= OWNER_INSTR;
      end else begin
         lock       <= mem_req && !bus.mem_gnt_i;
         lock_owner <= sel;
         if (grant) rr_last <= sel;
      end
   end

   obi_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_owner_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .pop   (bus.mem_rvalid_i),
      .din   (sel),
      .head  (head_bit),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign head_owner = owner_e'(head_bit);
   // A response with nothing outstanding is dropped here rather than routed anywhere.
   assign resp       = bus.mem_rvalid_i && !fifo_empty;

   assign bus.instr_rvalid_o = resp && (head_owner == OWNER_INSTR);
   assign bus.data_rvalid_o  = resp && (head_owner == OWNER_DATA);
   assign bus.instr_rdata_o  = bus.mem_rdata_i;
   assign bus.data_rdata_o   = bus.mem_rdata_i;
   assign bus.instr_err_o    = bus.instr_rvalid_o && bus.mem_err_i;
   assign bus.data_err_o     = bus.data_rvalid_o && bus.mem_err_i;

   a_no_req_when_full : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full |-> !mem_req);

   a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rst_n)
      bus.mem_rvalid_i |-> !fifo_empty)
      else $warning("obi_core_arbiter: response with no outstanding grant dropped");
endmodule

// File: tb/tb_obi_core_arbiter.sv
// Directed bench for obi_core_arbiter: a queue-based owner model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_obi_core_arbiter;
   import obi_arb_pkg::*;

   localparam int MAX = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obi_core_arbiter_if bus ();

   obi_core_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of owners in grant order, last granted owner, pending (ungranted) owner.
   bit mq[$];
   bit m_last;
   bit m_held;
   bit m_held_owner;
   bit e_sel, e_mreq, e_resp;

   always @(negedge clk) begin
      if (!rst_n) begin
         e_mreq = 1'b0;
         e_resp = 1'b0;
         chk("rst_mem_req", bus.mem_req_o, 0);
         chk("rst_instr_gnt", bus.instr_gnt_o, 0);
         chk("rst_data_gnt", bus.data_gnt_o, 0);
         chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
         chk("rst_data_rvalid", bus.data_rvalid_o, 0);
      end else begin
         if (m_held)                                e_sel = m_held_owner;
         else if (bus.instr_req_i && bus.data_req_i) e_sel = !m_last;
         else                                       e_sel = bus.data_req_i;
         e_mreq = (e_sel ? bus.data_req_i : bus.instr_req_i) && (mq.size() < MAX);
         e_resp = bus.mem_rvalid_i && (mq.size() > 0);
         chk("m_mem_req", bus.mem_req_o, e_mreq);
         chk("m_instr_gnt", bus.instr_gnt_o, e_mreq && bus.mem_gnt_i && !e_sel);
         chk("m_data_gnt", bus.data_gnt_o, e_mreq && bus.mem_gnt_i && e_sel);
         if (e_mreq) begin
            chk("m_addr", bus.mem_addr_o, e_sel ? bus.data_addr_i : bus.instr_addr_i);
            chk("m_we", bus.mem_we_o, e_sel ? bus.data_we_i : 1'b0);
            chk("m_be", bus.mem_be_o, e_sel ? bus.data_be_i : 4'hF);
            chk("m_wdata", bus.mem_wdata_o, e_sel ? bus.data_wdata_i : 32'h0);
         end
         chk("m_instr_rvalid", bus.instr_rvalid_o, e_resp && mq[0] == 1'b0);
         chk("m_data_rvalid", bus.data_rvalid_o, e_resp && mq[0] == 1'b1);
         if (e_resp && mq[0] == 1'b0) begin
            chk("m_instr_rdata", bus.instr_rdata_o, bus.mem_rdata_i);
            chk("m_instr_err", bus.instr_err_o, bus.mem_err_i);
         end
         if (e_resp && mq[0] == 1'b1) begin
            chk("m_data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
            chk("m_data_err", bus.data_err_o, bus.mem_err_i);
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_last = 1'b1;
         m_held = 1'b0;
         m_held_owner = 1'b0;
      end else begin
         if (e_resp) void'(mq.pop_front());
         if (e_mreq && bus.mem_gnt_i) begin
            mq.push_back(e_sel);
            m_last = e_sel;
         end
         m_held = e_mreq && !bus.mem_gnt_i;
         m_held_owner = e_sel;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = 32'h0;
      bus.data_req_i   = 1'b0;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = 4'h0;
      bus.data_addr_i  = 32'h0;
      bus.data_wdata_i = 32'h0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'h0;
      bus.mem_err_i    = 1'b0;
   endtask

   initial begin
      idle_inputs();
      bus.instr_req_i = 1'b1;
      bus.mem_gnt_i   = 1'b1;
      @(negedge clk);
      chk("reset_mem_req_gated", bus.mem_req_o, 0);
      chk("reset_instr_gnt", bus.instr_gnt_o, 0);
      step();
      step();
      rst_n = 1'b1;

      // Contention after reset: instruction first, then the data write.
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0100;
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 4'b0011;
      bus.data_addr_i  = 32'h2000_0000;
      bus.data_wdata_i = 32'h1234_5678;
      bus.mem_gnt_i    = 1'b1;
      @(negedge clk);
      chk("rr_first_instr_gnt", bus.instr_gnt_o, 1);
      chk("rr_first_data_gnt", bus.data_gnt_o, 0);
      chk("rr_first_addr", bus.mem_addr_o, 32'h0000_0100);
      chk("rr_first_be", bus.mem_be_o, 4'hF);
      chk("rr_first_wdata", bus.mem_wdata_o, 0);
      step();
      @(negedge clk);
      chk("rr_second_data_gnt", bus.data_gnt_o, 1);
      chk("rr_second_we", bus.mem_we_o, 1);
      chk("rr_second_be", bus.mem_be_o, 4'b0011);
      chk("rr_second_addr", bus.mem_addr_o, 32'h2000_0000);
      step();
      bus.instr_req_i  = 1'b0;
      bus.data_req_i   = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hAAAA_0001;
      bus.mem_err_i    = 1'b0;
      @(negedge clk);
      chk("order1_instr_rvalid", bus.instr_rvalid_o, 1);
      chk("order1_data_rvalid", bus.data_rvalid_o, 0);
      chk("order1_instr_rdata", bus.instr_rdata_o, 32'hAAAA_0001);
      step();
      bus.mem_rdata_i = 32'hBBBB_0002;
      bus.mem_err_i   = 1'b1;
      @(negedge clk);
      chk("order2_data_rvalid", bus.data_rvalid_o, 1);
      chk("order2_instr_rvalid", bus.instr_rvalid_o, 0);
      chk("order2_data_err", bus.data_err_o, 1);
      step();
      idle_inputs();

      // Lock: data stalled without grant while instruction starts requesting.
      bus.data_req_i  = 1'b1;
      bus.data_be_i   = 4'hF;
      bus.data_addr_i = 32'h2000_0000;
      @(negedge clk);
      chk("lock_c1_addr", bus.mem_addr_o, 32'h2000_0000);
      step();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0100;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("lock_hold_addr", bus.mem_addr_o, 32'h2000_0000);
         chk("lock_hold_instr_gnt", bus.instr_gnt_o, 0);
         step();
      end
      bus.mem_gnt_i = 1'b1;
      @(negedge clk);
      chk("lock_release_data_gnt", bus.data_gnt_o, 1);
      chk("lock_release_instr_gnt", bus.instr_gnt_o, 0);
      step();
      bus.data_req_i = 1'b0;
      @(negedge clk);
      chk("lock_after_instr_gnt", bus.instr_gnt_o, 1);
      step();
      bus.instr_req_i  = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h0000_0011;
      @(negedge clk);
      chk("lock_resp1_data_rvalid", bus.data_rvalid_o, 1);
      step();
      @(negedge clk);
      chk("lock_resp2_instr_rvalid", bus.instr_rvalid_o, 1);
      step();
      idle_inputs();

      // Full: two outstanding instruction fetches block a third until a response.
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0400;
      bus.mem_gnt_i    = 1'b1;
      @(negedge clk);
      chk("full_g1", bus.instr_gnt_o, 1);
      step();
      @(negedge clk);
      chk("full_g2", bus.instr_gnt_o, 1);
      step();
      @(negedge clk);
      chk("full_blocked_req", bus.mem_req_o, 0);
      chk("full_blocked_gnt", bus.instr_gnt_o, 0);
      step();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("full_pop_rvalid", bus.instr_rvalid_o, 1);
      chk("full_pop_rdata", bus.instr_rdata_o, 32'hDEAD_BEEF);
      chk("full_no_bypass", bus.mem_req_o, 0);
      step();
      bus.mem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("full_reassert", bus.mem_req_o, 1);
      step();
      bus.instr_req_i  = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("full_drain_rvalid", bus.instr_rvalid_o, 1);
         step();
      end
      idle_inputs();

      // Steady push+pop at one outstanding for ten cycles.
      bus.instr_req_i = 1'b1;
      bus.mem_gnt_i   = 1'b1;
      @(negedge clk);
      chk("steady_prime", bus.instr_gnt_o, 1);
      for (int c = 0; c < 10; c++) begin
         step();
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = 32'h5000_0000 + 32'(c);
         @(negedge clk);
         chk("steady_rvalid", bus.instr_rvalid_o, 1);
         chk("steady_req", bus.mem_req_o, 1);
      end
      step();
      bus.instr_req_i = 1'b0;
      bus.mem_gnt_i   = 1'b0;
      @(negedge clk);
      chk("steady_last_rvalid", bus.instr_rvalid_o, 1);
      step();
      @(negedge clk);
      chk("spurious_instr_rvalid", bus.instr_rvalid_o, 0);
      chk("spurious_data_rvalid", bus.data_rvalid_o, 0);
      step();
      idle_inputs();

      // Reset with two outstanding discards ownership.
      bus.instr_req_i = 1'b1;
      bus.data_req_i  = 1'b1;
      bus.data_be_i   = 4'hF;
      bus.mem_gnt_i   = 1'b1;
      @(negedge clk);
      chk("rst_pre_data_gnt", bus.data_gnt_o, 1);
      step();
      @(negedge clk);
      chk("rst_pre_instr_gnt", bus.instr_gnt_o, 1);
      step();
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      step();
      rst_n = 1'b1;
      bus.mem_rvalid_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("post_rst_instr_rvalid", bus.instr_rvalid_o, 0);
         chk("post_rst_data_rvalid", bus.data_rvalid_o, 0);
         step();
      end
      bus.mem_rvalid_i = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.data_req_i   = 1'b1;
      bus.mem_gnt_i    = 1'b1;
      @(negedge clk);
      chk("post_rst_instr_wins", bus.instr_gnt_o, 1);
      chk("post_rst_data_loses", bus.data_gnt_o, 0);
      step();
      idle_inputs();

      // Mixed traffic, responses only while something is outstanding.
      for (int c = 0; c < 300; c++) begin
         step();
         bus.instr_req_i  = 1'($urandom_range(0, 1));
         bus.instr_addr_i = $urandom;
         bus.data_req_i   = 1'($urandom_range(0, 1));
         bus.data_we_i    = 1'($urandom_range(0, 1));
         bus.data_be_i    = 4'($urandom_range(0, 15));
         bus.data_addr_i  = $urandom;
         bus.data_wdata_i = $urandom;
         bus.mem_gnt_i    = 1'($urandom_range(0, 1));
         bus.mem_rvalid_i = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
         bus.mem_rdata_i  = $urandom;
         bus.mem_err_i    = 1'($urandom_range(0, 1));
      end
      step();
      idle_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
